// File: rtl/baud_gen_frac.sv
// Fractional baud generator: rx oversample tick plus tx bit tick; define BAUDGEN_FRAC_EN to build the fractional accumulators.
// Latency: ticks are registered; the first tick after a restart lands INT edges later and the first tx bit D edges later.
// Backpressure: none; divisor writes are held pending and applied on a tx bit boundary or while enable is low.
module baud_gen_frac #(
    parameter int CLK_HZ       = 50000000,
    parameter int DEFAULT_BAUD = 115200,
    parameter int OVERSAMPLE   = 16,
    parameter int FRAC_W       = 4,
    parameter int DIV_W        = 16,
    parameter int DEFAULT_DIV  = int'((64'(CLK_HZ) * (64'd1 << FRAC_W)
                                       + 64'(DEFAULT_BAUD * OVERSAMPLE) / 2)
                                      / 64'(DEFAULT_BAUD * OVERSAMPLE))
) (
    input  logic             clk_50m,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div_in,
    input  logic             rx_resync,
    output logic             rxclk_en,
    output logic             txclk_en,
    output logic             div_pending
);

    localparam int INT_W = DIV_W - FRAC_W;
    localparam int SUB_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
    localparam logic [INT_W-1:0] INT_ONE  = INT_W'(1);
    localparam logic [INT_W-1:0] INT_TWO  = INT_W'(2);
    localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEFAULT_DIV);
`ifdef BAUDGEN_FRAC_EN
    localparam logic [FRAC_W-1:0] FRAC_MASK = '1;
`else
    localparam logic [FRAC_W-1:0] FRAC_MASK = '0;
`endif

    function automatic logic [INT_W-1:0] clamp_int(input logic [INT_W-1:0] i);
        return (i < INT_TWO) ? INT_TWO : i;
    endfunction

    localparam logic [INT_W-1:0] RST_CNT = clamp_int(DEF_DIV_V[DIV_W-1:FRAC_W]) - INT_ONE;

    logic [DIV_W-1:0]  div_q, div_d, pend_div_q, pend_div_d, div_nxt;
    logic              pend_q, pend_d;
    logic [INT_W-1:0]  int_act, int_new;
    logic [FRAC_W-1:0] frac_act;
    logic [INT_W-1:0]  rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic              rx_tick_q, rx_tick_d, tx_tick_q, tx_tick_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic              rx_hit, tx_hit, tx_bnd, apply;
    logic              rx_carry, tx_carry;

`ifdef BAUDGEN_FRAC_EN
    logic [FRAC_W-1:0] rx_acc_q, rx_acc_d, tx_acc_q, tx_acc_d;

    // The reload uses the carry of the following accumulation, so a period is
    // stretched before the wrap lands; the first 2^FRAC_W periods then sum to D.
    function automatic logic [FRAC_W:0] acc_step(input logic [FRAC_W-1:0] acc,
                                                 input logic [FRAC_W-1:0] frac);
        logic [FRAC_W-1:0] nxt;
        logic [FRAC_W:0]   ahead;
        nxt   = acc + frac;
        ahead = {1'b0, nxt} + {1'b0, frac};
        return {ahead[FRAC_W], nxt};
    endfunction
`endif

    always_comb begin
        int_act  = clamp_int(div_q[DIV_W-1:FRAC_W]);
        frac_act = (div_q[DIV_W-1:FRAC_W] < INT_TWO) ? '0 : (div_q[FRAC_W-1:0] & FRAC_MASK);

        rx_hit  = (rx_cnt_q == '0);
        tx_hit  = (tx_cnt_q == '0);
        tx_bnd  = enable && tx_hit && (sub_q == SUB_LAST);
        apply   = pend_q && (!enable || tx_bnd);
        div_nxt = apply ? pend_div_q : div_q;
        int_new = clamp_int(div_nxt[DIV_W-1:FRAC_W]);
        div_d   = div_nxt;

        pend_d     = pend_q && !apply;
        pend_div_d = pend_div_q;
        if (div_wr) begin
            pend_d     = 1'b1;
            pend_div_d = div_in;
        end

`ifdef BAUDGEN_FRAC_EN
        {rx_carry, rx_acc_d} = rx_hit ? acc_step(rx_acc_q, frac_act) : {1'b0, rx_acc_q};
        {tx_carry, tx_acc_d} = tx_hit ? acc_step(tx_acc_q, frac_act) : {1'b0, tx_acc_q};
`else
        // frac_act is masked to zero here, so both carries are constant zero.
        rx_carry = |frac_act;
        tx_carry = |frac_act;
`endif

        rx_cnt_d  = rx_hit ? (int_act - INT_ONE + {{(INT_W-1){1'b0}}, rx_carry})
                           : (rx_cnt_q - INT_ONE);
        rx_tick_d = rx_hit;
        tx_cnt_d  = tx_hit ? (int_act - INT_ONE + {{(INT_W-1){1'b0}}, tx_carry})
                           : (tx_cnt_q - INT_ONE);
        sub_d     = tx_hit ? ((sub_q == SUB_LAST) ? '0 : sub_q + SUB_W'(1)) : sub_q;
        tx_tick_d = tx_bnd;

        if (!enable) begin
            rx_cnt_d  = int_new - INT_ONE;
            tx_cnt_d  = int_new - INT_ONE;
            sub_d     = '0;
            rx_tick_d = 1'b0;
            tx_tick_d = 1'b0;
`ifdef BAUDGEN_FRAC_EN
            rx_acc_d  = '0;
            tx_acc_d  = '0;
`endif
        end else begin
            // Resync beats a coincident rx tick; an apply keeps the tick already due.
            if (rx_resync || apply) begin
                rx_cnt_d = int_new - INT_ONE;
`ifdef BAUDGEN_FRAC_EN
                rx_acc_d = '0;
`endif
            end
            if (rx_resync) begin
                rx_tick_d = 1'b0;
            end
            if (apply) begin
                tx_cnt_d = int_new - INT_ONE;
                sub_d    = '0;
`ifdef BAUDGEN_FRAC_EN
                tx_acc_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= DEF_DIV_V;
            pend_div_q <= DEF_DIV_V;
            pend_q     <= 1'b0;
            rx_cnt_q   <= RST_CNT;
            tx_cnt_q   <= RST_CNT;
            rx_tick_q  <= 1'b0;
            tx_tick_q  <= 1'b0;
            sub_q      <= '0;
        end else begin
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_tick_q  <= rx_tick_d;
            tx_tick_q  <= tx_tick_d;
            sub_q      <= sub_d;
        end
    end

`ifdef BAUDGEN_FRAC_EN
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_acc_q <= '0;
            tx_acc_q <= '0;
        end else begin
            rx_acc_q <= rx_acc_d;
            tx_acc_q <= tx_acc_d;
        end
    end
`endif

    assign rxclk_en    = rx_tick_q;
    assign txclk_en    = tx_tick_q;
    assign div_pending = pend_q;

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
Parametrised, runtime-programmable baud rate generator that replaces the fixed-ratio generator.
- Divides clk_50m by a fixed-point divisor with FRAC_W fractional bits, so the average rate is exact rather than truncated.
- Produces an oversampled rx enable that can be re-phased on start-bit detect, plus an independent tx bit enable.
- Feeds the uart rx/tx engines; divisor updates are applied glitch-free on tx bit boundaries.

Parameters:
- CLK_HZ, 50000000: clock frequency; used only to compute DEFAULT_DIV.
- DEFAULT_BAUD, 115200: baud rate after reset.
- OVERSAMPLE, 16: rx ticks per bit. Legal range 2..64.
- FRAC_W, 4: fractional bits in the divisor.
- DIV_W, 16: total divisor width, integer plus fractional bits.
- DEFAULT_DIV, round(CLK_HZ*2^FRAC_W/(DEFAULT_BAUD*OVERSAMPLE)): reset divisor; 434 for the defaults.

Ports:
- clk_50m  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  generator run. Low holds everything in the restart state.
- div_wr  in  1  single-cycle strobe; captures div_in.
- div_in  in  DIV_W  new divisor. INT = div_in[DIV_W-1:FRAC_W], FRAC = div_in[FRAC_W-1:0].
- rx_resync  in  1  single-cycle strobe; restarts the rx tick phase.
- rxclk_en  out  1  one-cycle pulse at OVERSAMPLE x the baud rate.
- txclk_en  out  1  one-cycle pulse at the baud rate.
- div_pending  out  1  a written divisor is waiting for the apply boundary.

Behaviour:
- Reset (async, rst_n=0): rxclk_en=0, txclk_en=0, div_pending=0. Active divisor = DEFAULT_DIV; counters and fractional accumulators in the restart state.
- Clamp: an effective INT below 2 is treated as divisor 2<<FRAC_W (32 for the defaults).
- Fractional divider, one instance each for rx and tx-base:
  - Restart state: cnt = INT-1, acc = 0.
  - Each enabled edge with cnt != 0: cnt decrements, tick output = 0.
  - Enabled edge with cnt == 0: tick registered to 1 for one cycle. {carry, acc} <= acc + FRAC. cnt <= INT-1+carry.
  - The first period after a restart is exactly INT cycles.
  - Any 2^FRAC_W consecutive periods sum to exactly D = INT*2^FRAC_W + FRAC cycles. Each period is INT or INT+1 cycles.
- Tick timing: if enable is first sampled high at edge 1, the first tick is registered at edge INT.
- rxclk_en is the rx divider tick.
- txclk_en:
  - sub counter 0..OVERSAMPLE-1 advances on each tx-base tick.
  - txclk_en is registered high on the base tick where sub == OVERSAMPLE-1, then sub wraps to 0.
  - tx bit period is exactly D cycles. The first txclk_en is at edge D.
- rx_resync:
  - Next edge forces the rx divider to the restart state; rxclk_en = 0 that cycle. Next rxclk_en is INT cycles later.
  - The tx path is unaffected.
  - rx_resync coinciding with an rx tick: resync wins and no tick is output.
- Divisor update:
  - div_wr loads the pending register; div_pending = 1 from the next cycle. Repeated writes before the apply boundary: the last write wins.
  - Apply boundary = the edge that registers txclk_en=1, or any edge while enable=0.
  - At the boundary: the pending value becomes active, div_pending <= 0, and both dividers and the sub counter restart using the new INT.
  - div_wr in the same cycle as the boundary: the older pending value (if any) is applied; the new value stays pending for the next boundary.
- enable low:
  - Next edge: outputs 0; both dividers and sub in the restart state; pending still applies (see Apply boundary).
  - Re-enable restarts the phase from zero.
- Width: acc is FRAC_W bits, wrapping modulo 2^FRAC_W; the carry is the only overflow used. cnt is DIV_W-FRAC_W bits.
- Async reset mid-operation or with an update pending: the pending value is discarded and the active divisor returns to DEFAULT_DIV.

Optional Feature:
- Macro BAUDGEN_FRAC_EN.
- Defined: the fractional accumulators operate as described.
- Undefined:
  - FRAC bits of every divisor (written and DEFAULT_DIV) are ignored and no accumulator is built.
  - Every period is exactly INT cycles; the tx period is INT*OVERSAMPLE.
  - The div_in width is unchanged.

Test Plan:
- Reset release, enable=1, default 434 (INT=27, FRAC=2) -> rxclk_en first at edge 27; any 16 consecutive rx periods sum to 434 (14x27 + 2x28); txclk_en at edges 434, 868, 1302.
- Mid-bit div_wr with 868 -> div_pending=1 until the next txclk_en; from that edge, txclk_en spacing is 868 and rx spacing is 54/55.
- rx_resync pulsed 10 cycles after an rxclk_en -> next rxclk_en exactly 27 cycles after the resync edge; txclk_en timing identical to an unperturbed run.
- div_wr with 16 (INT=1) then boundary -> clamped: rxclk_en every 2 cycles, txclk_en every 32 cycles.
- enable dropped mid-bit for 5 cycles -> both outputs 0 next cycle; after re-enable the first rxclk_en comes after 27 cycles and the first txclk_en after 434.
- div_wr with 868, then rst_n pulsed low before the boundary -> div_pending=0 and txclk_en spacing 434 after release. Build without BAUDGEN_FRAC_EN -> all rx periods 27, tx period 432.
